// File: rtl/rv_pkg.sv
// Shared encodings for the 64-bit RISC-V pipeline: ALUOp classes, ALU operations
// and the branch funct3 codes.
package rv_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/alu64.sv
// Combinational ALU. Shift amount is the low six bits of b.
module alu64
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  alu_op_e          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result
);

  logic [5:0] shamt;
  assign shamt = b[5:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SRA: result = $unsigned($signed(a) >>> shamt);
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM register: ALU control, ALU, branch compare/target,
// wrong-path squash after a taken branch, and saturating branch counters.
module ex_mem_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             IDEX_RegWrite,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_MemToReg,
  input  logic             IDEX_MemWrite,
  input  logic             IDEX_Branch,
  input  logic             IDEX_ALUSrc,
  input  logic [1:0]       IDEX_ALUOp,
  input  logic [3:0]       IDEX_Funct,
  input  logic [XLEN-1:0]  IDEX_PC_out,
  input  logic [XLEN-1:0]  IDEX_ReadData1,
  input  logic [XLEN-1:0]  IDEX_ReadData2,
  input  logic [XLEN-1:0]  IDEX_ImmData,
  input  logic [4:0]       IDEX_rd,
  output logic             EXMEM_RegWrite,
  output logic             EXMEM_MemRead,
  output logic             EXMEM_MemToReg,
  output logic             EXMEM_MemWrite,
  output logic             EXMEM_Branch,
  output logic [XLEN-1:0]  EXMEM_ALUResult,
  output logic [XLEN-1:0]  EXMEM_WriteData,
  output logic [XLEN-1:0]  EXMEM_BranchTarget,
  output logic             EXMEM_Zero,
  output logic [4:0]       EXMEM_rd,
  output logic             EXMEM_PCSrc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  alu_op_e         alu_op;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] branch_target;
  logic            cond;

  always_comb begin
    alu_op = ALU_ADD;
    case (IDEX_ALUOp)
      ALUOP_SUB: alu_op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (IDEX_Funct)
          4'b0000: alu_op = ALU_ADD;
          4'b1000: alu_op = ALU_SUB;
          4'b0111: alu_op = ALU_AND;
          4'b0110: alu_op = ALU_OR;
          4'b0100: alu_op = ALU_XOR;
          4'b0001: alu_op = ALU_SLL;
          4'b0101: alu_op = ALU_SRL;
          4'b1101: alu_op = ALU_SRA;
          default: alu_op = ALU_ADD;
        endcase
      end
      ALUOP_ITYPE: begin
        case (IDEX_Funct[2:0])
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b100:  alu_op = ALU_XOR;
          3'b001:  alu_op = ALU_SLL;
          3'b101:  alu_op = IDEX_Funct[3] ? ALU_SRA : ALU_SRL;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  assign op_b = IDEX_ALUSrc ? IDEX_ImmData : IDEX_ReadData2;

  alu64 #(.XLEN(XLEN)) u_alu (
    .op     (alu_op),
    .a      (IDEX_ReadData1),
    .b      (op_b),
    .result (alu_result)
  );

  always_comb begin
    cond = 1'b0;
    if (IDEX_Branch) begin
      case (IDEX_Funct[2:0])
        F3_BEQ:  cond = (IDEX_ReadData1 == IDEX_ReadData2);
        F3_BNE:  cond = (IDEX_ReadData1 != IDEX_ReadData2);
        F3_BLT:  cond = ($signed(IDEX_ReadData1) <  $signed(IDEX_ReadData2));
        F3_BGE:  cond = ($signed(IDEX_ReadData1) >= $signed(IDEX_ReadData2));
        default: cond = 1'b0;
      endcase
    end
  end

  assign branch_target = IDEX_PC_out + (IDEX_ImmData << 1);

  // PCSrc is derived from registered fields only, so it is itself a register output.
  assign EXMEM_PCSrc = EXMEM_Branch & EXMEM_Zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EXMEM_RegWrite     <= 1'b0;
      EXMEM_MemRead      <= 1'b0;
      EXMEM_MemToReg     <= 1'b0;
      EXMEM_MemWrite     <= 1'b0;
      EXMEM_Branch       <= 1'b0;
      EXMEM_Zero         <= 1'b0;
      EXMEM_ALUResult    <= '0;
      EXMEM_WriteData    <= '0;
      EXMEM_BranchTarget <= '0;
      EXMEM_rd           <= '0;
      branch_cnt         <= '0;
      taken_cnt          <= '0;
    end else if (!stall) begin
      EXMEM_ALUResult    <= alu_result;
      EXMEM_WriteData    <= IDEX_ReadData2;
      EXMEM_BranchTarget <= branch_target;
      EXMEM_rd           <= IDEX_rd;
      if (EXMEM_PCSrc) begin
        // Wrong-path instruction: bubble the controls, leave counters alone.
        EXMEM_RegWrite <= 1'b0;
        EXMEM_MemRead  <= 1'b0;
        EXMEM_MemToReg <= 1'b0;
        EXMEM_MemWrite <= 1'b0;
        EXMEM_Branch   <= 1'b0;
        EXMEM_Zero     <= 1'b0;
      end else begin
        EXMEM_RegWrite <= IDEX_RegWrite;
        EXMEM_MemRead  <= IDEX_MemRead;
        EXMEM_MemToReg <= IDEX_MemToReg;
        EXMEM_MemWrite <= IDEX_MemWrite;
        EXMEM_Branch   <= IDEX_Branch;
        EXMEM_Zero     <= cond;
        if (IDEX_Branch && (branch_cnt != '1))
          branch_cnt <= branch_cnt + 1'b1;
        if (cond && (taken_cnt != '1))
          taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with a reference model feeding a scoreboard queue.
module tb_ex_mem_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, stall;
  logic             IDEX_RegWrite, IDEX_MemRead, IDEX_MemToReg, IDEX_MemWrite;
  logic             IDEX_Branch, IDEX_ALUSrc;
  logic [1:0]       IDEX_ALUOp;
  logic [3:0]       IDEX_Funct;
  logic [XLEN-1:0]  IDEX_PC_out, IDEX_ReadData1, IDEX_ReadData2, IDEX_ImmData;
  logic [4:0]       IDEX_rd;
  logic             EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemToReg, EXMEM_MemWrite;
  logic             EXMEM_Branch, EXMEM_Zero, EXMEM_PCSrc;
  logic [XLEN-1:0]  EXMEM_ALUResult, EXMEM_WriteData, EXMEM_BranchTarget;
  logic [4:0]       EXMEM_rd;
  logic [CNT_W-1:0] branch_cnt, taken_cnt;

  ex_mem_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemToReg(IDEX_MemToReg), .IDEX_MemWrite(IDEX_MemWrite),
    .IDEX_Branch(IDEX_Branch), .IDEX_ALUSrc(IDEX_ALUSrc),
    .IDEX_ALUOp(IDEX_ALUOp), .IDEX_Funct(IDEX_Funct),
    .IDEX_PC_out(IDEX_PC_out), .IDEX_ReadData1(IDEX_ReadData1),
    .IDEX_ReadData2(IDEX_ReadData2), .IDEX_ImmData(IDEX_ImmData),
    .IDEX_rd(IDEX_rd),
    .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemRead(EXMEM_MemRead),
    .EXMEM_MemToReg(EXMEM_MemToReg), .EXMEM_MemWrite(EXMEM_MemWrite),
    .EXMEM_Branch(EXMEM_Branch), .EXMEM_ALUResult(EXMEM_ALUResult),
    .EXMEM_WriteData(EXMEM_WriteData), .EXMEM_BranchTarget(EXMEM_BranchTarget),
    .EXMEM_Zero(EXMEM_Zero), .EXMEM_rd(EXMEM_rd), .EXMEM_PCSrc(EXMEM_PCSrc),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]      ctrl;   // {RegWrite, MemRead, MemToReg, MemWrite, Branch, Zero}
    logic            pcsrc;
    logic [3:0]      bc;
    logic [3:0]      tc;
    logic [63:0]     res;
    logic [63:0]     wd;
    logic [63:0]     tgt;
    logic [4:0]      rd;
    logic            chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t m_last;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_alu(input logic [1:0] aluop, input logic [3:0] f,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [5:0] sh;
    sh = b[5:0];
    if (aluop == 2'b01) return a - b;
    if (aluop == 2'b10) begin
      if (f == 4'b1000) return a - b;
      if (f == 4'b0111) return a & b;
      if (f == 4'b0110) return a | b;
      if (f == 4'b0100) return a ^ b;
      if (f == 4'b0001) return a << sh;
      if (f == 4'b0101) return a >> sh;
      if (f == 4'b1101) return $unsigned($signed(a) >>> sh);
      return a + b;
    end
    if (aluop == 2'b11) begin
      if (f[2:0] == 3'b111) return a & b;
      if (f[2:0] == 3'b110) return a | b;
      if (f[2:0] == 3'b100) return a ^ b;
      if (f[2:0] == 3'b001) return a << sh;
      if (f[2:0] == 3'b101) return f[3] ? $unsigned($signed(a) >>> sh) : a >> sh;
      return a + b;
    end
    return a + b;
  endfunction

  function automatic logic model_cond(input logic br, input logic [2:0] f3,
                                      input logic [63:0] a, input logic [63:0] b);
    if (!br) return 1'b0;
    if (f3 == 3'b000) return a == b;
    if (f3 == 3'b001) return a != b;
    if (f3 == 3'b100) return $signed(a) < $signed(b);
    if (f3 == 3'b101) return !($signed(a) < $signed(b));
    return 1'b0;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'h1;
  endfunction

  task automatic drive(input logic [1:0] aluop, input logic [3:0] f, input logic alusrc,
                       input logic br, input logic rw, input logic mr, input logic m2r,
                       input logic mw, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] imm, input logic [63:0] pc, input logic [4:0] rd);
    IDEX_ALUOp = aluop; IDEX_Funct = f; IDEX_ALUSrc = alusrc; IDEX_Branch = br;
    IDEX_RegWrite = rw; IDEX_MemRead = mr; IDEX_MemToReg = m2r; IDEX_MemWrite = mw;
    IDEX_ReadData1 = a; IDEX_ReadData2 = b; IDEX_ImmData = imm; IDEX_PC_out = pc;
    IDEX_rd = rd;
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".ctrl"}, {58'd0, EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemToReg,
                           EXMEM_MemWrite, EXMEM_Branch, EXMEM_Zero}, {58'd0, e.ctrl});
    check({tag, ".pcsrc"}, {63'd0, EXMEM_PCSrc}, {63'd0, e.pcsrc});
    check({tag, ".bcnt"}, {60'd0, branch_cnt}, {60'd0, e.bc});
    check({tag, ".tcnt"}, {60'd0, taken_cnt}, {60'd0, e.tc});
    if (e.chk_data) begin
      check({tag, ".res"}, EXMEM_ALUResult, e.res);
      check({tag, ".wd"}, EXMEM_WriteData, e.wd);
      check({tag, ".tgt"}, EXMEM_BranchTarget, e.tgt);
      check({tag, ".rd"}, {59'd0, EXMEM_rd}, {59'd0, e.rd});
    end
  endtask

  task automatic step(input string tag, input logic st);
    exp_t e, got;
    logic c;
    stall = st;
    if (st) begin
      e = m_last;
    end else begin
      e = m_last;
      e.res = model_alu(IDEX_ALUOp, IDEX_Funct, IDEX_ReadData1,
                        IDEX_ALUSrc ? IDEX_ImmData : IDEX_ReadData2);
      e.wd  = IDEX_ReadData2;
      e.tgt = IDEX_PC_out + (IDEX_ImmData << 1);
      e.rd  = IDEX_rd;
      c = model_cond(IDEX_Branch, IDEX_Funct[2:0], IDEX_ReadData1, IDEX_ReadData2);
      if (m_last.pcsrc) begin
        e.ctrl = '0;
        e.chk_data = 1'b0;
      end else begin
        e.ctrl = {IDEX_RegWrite, IDEX_MemRead, IDEX_MemToReg, IDEX_MemWrite, IDEX_Branch, c};
        e.chk_data = 1'b1;
        if (IDEX_Branch) e.bc = sat_inc(e.bc);
        if (c) e.tc = sat_inc(e.tc);
      end
      e.pcsrc = e.ctrl[1] & e.ctrl[0];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    compare(tag, got);
    m_last = got;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ctrl"}, {57'd0, EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemToReg,
                           EXMEM_MemWrite, EXMEM_Branch, EXMEM_Zero, EXMEM_PCSrc}, 64'd0);
    check({tag, ".data"}, EXMEM_ALUResult | EXMEM_WriteData | EXMEM_BranchTarget, 64'd0);
    check({tag, ".rd_cnt"}, {51'd0, EXMEM_rd, branch_cnt, taken_cnt}, 64'd0);
  endtask

  task automatic model_reset();
    m_last = '0;
    m_last.chk_data = 1'b1;
  endtask

  task automatic async_reset(input string tag);
    #3 reset = 1'b1;
    #1 check_zero(tag);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] rfun [6];
    logic [2:0] ifun [5];
    rfun = '{4'b0111, 4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};
    ifun = '{3'b111, 3'b110, 3'b100, 3'b001, 3'b000};
    reset = 1'b1;
    stall = 1'b0;
    drive(2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    drive(2'b10, 4'b0000, 0, 0, 1, 0, 0, 0, 64'd5, 64'd7, 64'd0, 64'h40, 5'd3);
    step("r_add", 0);
    check("r_add_const", EXMEM_ALUResult, 64'd12);
    drive(2'b10, 4'b1000, 0, 0, 1, 0, 0, 0, 64'd5, 64'd7, 64'd0, 64'h44, 5'd3);
    step("r_sub", 0);
    check("r_sub_const", EXMEM_ALUResult, 64'hFFFF_FFFF_FFFF_FFFE);

    foreach (rfun[i]) begin
      drive(2'b10, rfun[i], 0, 0, 1, 0, 0, 0, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 64'h48, 5'(i + 4));
      step("r_op", 0);
    end
    drive(2'b10, 4'b0010, 0, 0, 1, 0, 0, 0, 64'd9, 64'd4, 64'd0, 64'h4c, 5'd10);
    step("r_undef", 0);

    drive(2'b11, 4'b1101, 1, 0, 1, 0, 0, 0, 64'h8000_0000_0000_0000, 64'd3, 64'd4,
          64'h50, 5'd11);
    step("i_sra", 0);
    check("i_sra_const", EXMEM_ALUResult, 64'hF800_0000_0000_0000);
    drive(2'b11, 4'b0101, 1, 0, 1, 0, 0, 0, 64'h8000_0000_0000_0000, 64'd3, 64'd4,
          64'h54, 5'd12);
    step("i_srl", 0);
    foreach (ifun[i]) begin
      drive(2'b11, {1'b1, ifun[i]}, 1, 0, 1, 0, 0, 0, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, 64'h58, 5'd13);
      step("i_op", 0);
    end
    drive(2'b00, 4'b0111, 1, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hABCD, 64'h20,
          64'h60, 5'd0);
    step("st_add", 0);
    drive(2'b01, 4'b0000, 0, 0, 1, 1, 1, 0, 64'd3, 64'd10, 64'd0, 64'h64, 5'd14);
    step("ld_sub", 0);

    drive(2'b01, 4'b0000, 0, 1, 0, 0, 0, 0, 64'd9, 64'd9, 64'd8, 64'h100, 5'd0);
    step("beq_taken", 0);
    check("beq_pcsrc", {63'd0, EXMEM_PCSrc}, 64'd1);
    check("beq_tgt", EXMEM_BranchTarget, 64'h110);
    drive(2'b10, 4'b0000, 0, 0, 1, 0, 0, 0, 64'd1, 64'd1, 64'd0, 64'h104, 5'd5);
    step("squash", 0);
    check("squash_rw", {62'd0, EXMEM_RegWrite, EXMEM_PCSrc}, 64'd0);

    drive(2'b01, 4'b0001, 0, 1, 0, 0, 0, 0, 64'd1, 64'd2, 64'h10, 64'h200, 5'd0);
    step("bne_taken", 0);
    drive(2'b10, 4'b0000, 0, 0, 1, 0, 0, 1, 64'd7, 64'd8, 64'd0, 64'h204, 5'd6);
    repeat (3) step("stall_hold", 1);
    check("stall_pcsrc", {63'd0, EXMEM_PCSrc}, 64'd1);
    step("stall_bubble", 0);

    drive(2'b01, 4'b0001, 0, 1, 0, 0, 0, 0, 64'd4, 64'd4, 64'd2, 64'h300, 5'd0);
    step("bne_nt", 0);
    drive(2'b01, 4'b0100, 0, 1, 0, 0, 0, 0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
          64'h304, 5'd0);
    step("blt_nt", 0);
    drive(2'b01, 4'b0010, 0, 1, 0, 0, 0, 0, 64'd5, 64'd5, 64'd2, 64'h308, 5'd0);
    step("br_f3_undef", 0);
    drive(2'b01, 4'b0000, 0, 0, 0, 0, 0, 0, 64'd5, 64'd5, 64'd2, 64'h30c, 5'd0);
    step("nobranch_eq", 0);
    drive(2'b01, 4'b0101, 0, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'h310, 5'd0);
    step("bge_eq_negimm", 0);

    drive(2'b01, 4'b0000, 0, 1, 0, 0, 0, 0, 64'd1, 64'd1, 64'd2, 64'h400, 5'd0);
    step("beq_pre_rst", 0);
    stall = 1'b1;
    async_reset("rst_mid_pcsrc");

    drive(2'b01, 4'b0100, 0, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd4,
          64'h500, 5'd0);
    step("blt_neg", 0);
    check("blt_taken_cnt", {60'd0, taken_cnt}, 64'd1);
    for (int i = 0; i < 34; i++) begin
      drive(2'b01, 4'b0001, 0, 1, 0, 0, 0, 0, 64'd1, 64'd2, 64'd4, 64'h600, 5'd0);
      step("sat_bne", 0);
    end
    check("sat_bcnt", {60'd0, branch_cnt}, 64'd15);
    check("sat_tcnt", {60'd0, taken_cnt}, 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Execute stage plus EX/MEM pipeline register of the 5-stage 64-bit RISC-V pipeline.
- Consumes the ID/EX register outputs and performs ALU control decode, the 64-bit ALU, branch-condition evaluation and branch-target add.
- Registers the results for the MEM stage.
- Drives the registered PCSrc/flush used to redirect fetch and squash wrong-path instructions.
- Keeps saturating branch statistics counters.

Parameters:
XLEN, 64, datapath width
CNT_W, 32, width of each branch statistics counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold all EX/MEM state (MEM stage busy)
IDEX_RegWrite, IDEX_MemRead, IDEX_MemToReg, IDEX_MemWrite, IDEX_Branch, IDEX_ALUSrc  in  1 each  control from ID/EX
IDEX_ALUOp  in  2  ALU operation class
IDEX_Funct  in  4  {funct7[5], funct3}
IDEX_PC_out, IDEX_ReadData1, IDEX_ReadData2, IDEX_ImmData  in  XLEN each  PC, operands, immediate
IDEX_rd  in  5  destination register
EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemToReg, EXMEM_MemWrite, EXMEM_Branch  out  1 each  registered control
EXMEM_ALUResult  out  XLEN  registered ALU result
EXMEM_WriteData  out  XLEN  registered store data (IDEX_ReadData2)
EXMEM_BranchTarget  out  XLEN  registered PC + (Imm << 1)
EXMEM_Zero  out  1  registered branch condition true
EXMEM_rd  out  5  registered destination
EXMEM_PCSrc  out  1  EXMEM_Branch & EXMEM_Zero; redirect fetch and flush IF/ID and ID/EX
branch_cnt  out  CNT_W  branches committed into EX/MEM
taken_cnt  out  CNT_W  taken branches committed into EX/MEM

Behaviour:
- Reset is asynchronous and active-high. While reset is high, every output above is 0, including both counters. Release is synchronous to the next rising clk.
- ALU control:
  - ALUOp 00: add.
  - ALUOp 01: sub.
  - ALUOp 10 (R-type), by Funct: 0000 add, 1000 sub, 0111 and, 0110 or, 0100 xor, 0001 sll, 0101 srl, 1101 sra.
  - ALUOp 11 (I-type), by Funct[2:0]: 000 add, 111 and, 110 or, 100 xor, 001 sll; 101 is srl when Funct[3]=0 and sra when Funct[3]=1.
  - Any undefined code: add.
- Operand B = ALUSrc ? ImmData : ReadData2. Shift amount = B[5:0]. Arithmetic wraps modulo 2^XLEN.
- Branch condition, by Funct[2:0], on signed compare of ReadData1 vs ReadData2: 000 beq (equal), 001 bne, 100 blt (signed less), 101 bge (signed greater-or-equal). Other encodings: false. The condition is evaluated only when IDEX_Branch=1; otherwise Zero is 0.
- Branch target = IDEX_PC_out + (IDEX_ImmData << 1), mod 2^XLEN.
- Latency: one cycle. EX inputs present at edge N appear on the EXMEM_* outputs after edge N.
- Priority at each rising edge:
  1. stall=1: all EX/MEM registers and counters hold. EXMEM_PCSrc stays asserted if it was asserted.
  2. Else if EXMEM_PCSrc=1: the instruction in EX is wrong-path. Load a bubble: RegWrite, MemRead, MemToReg, MemWrite, Branch and Zero are 0. Data fields load normally (don't-care). Counters do not increment. Consequently PCSrc deasserts after exactly one non-stalled cycle.
  3. Else: load normally. branch_cnt increments if IDEX_Branch=1; taken_cnt increments if IDEX_Branch=1 and the condition is true.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- Reset mid-operation (including during stall or PCSrc=1) clears everything immediately.

Decomposition:
- Shared package rv_pkg holds:
  - ALUOp encodings.
  - ALU operation enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA).
  - Branch funct3 constants (BEQ, BNE, BLT, BGE).
  - XLEN default.
- One natural sub-module, alu64: purely combinational, takes the op enum and A, B; outputs the result. ALU control decode, branch compare and the register stay in ex_mem_stage.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with a nonzero pipeline state -> all outputs 0 immediately, before the next edge.
- R-type add: ALUOp=10, Funct=0000, RD1=5, RD2=7, RegWrite=1, rd=3 -> after one edge EXMEM_ALUResult=12, EXMEM_RegWrite=1, EXMEM_rd=3. With Funct=1000 -> result 0xFFFF_FFFF_FFFF_FFFE.
- I-type sra: ALUOp=11, Funct=1101, ALUSrc=1, RD1=0x8000_0000_0000_0000, Imm=4 -> result 0xF800_0000_0000_0000.
- Taken beq with squash: Branch=1, Funct=0000, RD1=RD2=9, PC=0x100, Imm=8 -> EXMEM_PCSrc=1, BranchTarget=0x110, branch_cnt=1, taken_cnt=1. Next edge, with a RegWrite=1 instruction in EX -> EXMEM_RegWrite=0 and PCSrc=0.
- Stall hold: with PCSrc=1, hold stall=1 for 3 cycles -> all EXMEM outputs and counters unchanged, PCSrc stays 1. On the first unstalled edge a bubble loads.
- Saturation: CNT_W=4, issue 17 taken bne (RD1=1, RD2=2) -> branch_cnt=taken_cnt=15, no wrap. A blt with RD1=-1, RD2=0 counts as taken.
